pad_trigger_coincidence: RTL and testbench

PAD_TRIGGER_COINCIDENCE -- requirements
Module: pad_trigger_coincidence

---
 rtl/pad_trigger_coincidence_pkg.sv | 25 ++
 rtl/pad_majority_count.sv | 18 +
 rtl/pad_trigger_coincidence.sv | 200 ++++++++++++++++++++
 tb/tb_pad_trigger_coincidence.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_trigger_coincidence_pkg.sv
// Shared constants, state encoding and helpers for the pad trigger coincidence block.
// Pad words carry a 12-bit BCID in [115:104] above the hit field.
package pad_trigger_coincidence_pkg;

   localparam int C_PAD_W    = 116;
   localparam int C_HIT_W    = 104;
   localparam int C_BCID_MSB = 115;
   localparam int C_BCID_LSB = 104;
   localparam int C_BCID_W   = C_BCID_MSB - C_BCID_LSB + 1;
   localparam int C_NLINK    = 4;
   localparam int C_CNT_W    = 16;
   localparam int C_THR_W    = 3;
   localparam int C_DEAD_W   = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } trig_state_e;

   // Thresholds above the number of links behave as "all links must agree".
   function automatic logic [C_THR_W-1:0] eff_threshold(input logic [C_THR_W-1:0] thr);
      return (thr > 3'd4) ? 3'd4 : thr;
   endfunction

endpackage

// File: rtl/pad_majority_count.sv
// Per-hit-bit majority vote: population count of the four link bits against the threshold.
module pad_majority_count
   import pad_trigger_coincidence_pkg::*;
(
   input  logic [C_NLINK-1:0]  i_bits,
   input  logic [C_THR_W-1:0]  i_thr,
   output logic                o_coinc
);

   logic [2:0] w_count;

   assign w_count = {2'b00, i_bits[0]} + {2'b00, i_bits[1]}
                  + {2'b00, i_bits[2]} + {2'b00, i_bits[3]};

   // i_thr is already clamped to 0..4; zero disables the vote entirely.
   assign o_coinc = (i_thr != 3'd0) && (w_count >= i_thr);

endmodule

// File: rtl/pad_trigger_coincidence.sv
// Four-link pad coincidence trigger: BCID check and capture, per-bit majority vote,
// deadtime FSM with trigger/veto counters and sticky BCID error flags.
module pad_trigger_coincidence
   import pad_trigger_coincidence_pkg::*;
#(
   parameter int DEADTIME = 4,
   parameter int HIT_W    = C_HIT_W
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [C_PAD_W-1:0]   pad_data_0_aligned,
   input  logic [C_PAD_W-1:0]   pad_data_1_aligned,
   input  logic [C_PAD_W-1:0]   pad_data_2_aligned,
   input  logic [C_PAD_W-1:0]   pad_data_3_aligned,
   input  logic                 pad_data_valid_in,
   input  logic [1:0]           ref_sel,
   input  logic [C_THR_W-1:0]   threshold,
   input  logic                 err_clr,
   output logic                 trig_valid,
   output logic [C_BCID_W-1:0]  trig_bcid,
   output logic [HIT_W-1:0]     trig_hits,
   output logic [C_NLINK-1:0]   bcid_err,
   output logic [C_CNT_W-1:0]   trig_count,
   output logic [C_CNT_W-1:0]   veto_count
);

   localparam logic [C_DEAD_W-1:0] C_DEAD_LOAD = C_DEAD_W'(DEADTIME);
   localparam logic [C_CNT_W-1:0]  C_CNT_ONE   = C_CNT_W'(1);

   logic [C_PAD_W-1:0]  w_pad [C_NLINK];
   logic [C_BCID_W-1:0] w_ref_bcid;
   logic [C_NLINK-1:0]  w_mismatch;
   logic [C_NLINK-1:0]  w_err_set;

   assign w_pad[0] = pad_data_0_aligned;
   assign w_pad[1] = pad_data_1_aligned;
   assign w_pad[2] = pad_data_2_aligned;
   assign w_pad[3] = pad_data_3_aligned;

   assign w_ref_bcid = w_pad[ref_sel][C_BCID_MSB:C_BCID_LSB];

   for (genvar gi = 0; gi < C_NLINK; gi++) begin : g_link_cmp
      assign w_mismatch[gi] = (w_pad[gi][C_BCID_MSB:C_BCID_LSB] != w_ref_bcid);
   end

   assign w_err_set = {C_NLINK{pad_data_valid_in}} & w_mismatch;

   // Stage 1: capture match flags, reference BCID and raw hit fields.
   logic                r_s1_valid;
   logic [C_NLINK-1:0]  r_s1_match;
   logic [C_BCID_W-1:0] r_s1_bcid;
   logic [HIT_W-1:0]    r_s1_hits [C_NLINK];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_match <= '0;
         r_s1_bcid  <= '0;
         for (int li = 0; li < C_NLINK; li++) begin
            r_s1_hits[li] <= '0;
         end
      end else begin
         r_s1_valid <= pad_data_valid_in;
         if (pad_data_valid_in) begin
            r_s1_match <= ~w_mismatch;
            r_s1_bcid  <= w_ref_bcid;
            for (int li = 0; li < C_NLINK; li++) begin
               r_s1_hits[li] <= w_pad[li][HIT_W-1:0];
            end
         end
      end
   end

   // Stage 2: mismatching links are masked out before the vote.
   logic [C_THR_W-1:0] w_thr_eff;
   logic [HIT_W-1:0]   w_coinc;
   logic               w_cand;

   assign w_thr_eff = eff_threshold(threshold);

   for (genvar gi = 0; gi < HIT_W; gi++) begin : g_bit
      logic [C_NLINK-1:0] w_bits;
      for (genvar li = 0; li < C_NLINK; li++) begin : g_mask
         assign w_bits[li] = r_s1_match[li] & r_s1_hits[li][gi];
      end
      pad_majority_count u_maj (
         .i_bits  (w_bits),
         .i_thr   (w_thr_eff),
         .o_coinc (w_coinc[gi])
      );
   end

   assign w_cand = r_s1_valid & (|w_coinc);

   // Deadtime FSM
   trig_state_e         r_state;
   trig_state_e         w_state_next;
   logic [C_DEAD_W-1:0] r_dead;
   logic [C_DEAD_W-1:0] w_dead_next;
   logic                w_issue;
   logic                w_veto;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_dead  <= '0;
      end else begin
         r_state <= w_state_next;
         r_dead  <= w_dead_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dead_next  = r_dead;
      w_issue      = 1'b0;
      w_veto       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cand) begin
               w_issue      = 1'b1;
               w_dead_next  = C_DEAD_LOAD;
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_veto      = w_cand;
            w_dead_next = r_dead - 4'd1;
            // Leaving on the edge where the count hits zero frees the very next cycle.
            if (r_dead <= 4'd1) begin
               w_state_next = ST_IDLE;
               w_dead_next  = '0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_dead_next  = '0;
         end
      endcase
   end

   // Trigger outputs, counters and sticky error flags.
   logic                r_trig_valid;
   logic [C_BCID_W-1:0] r_trig_bcid;
   logic [HIT_W-1:0]    r_trig_hits;
   logic [C_NLINK-1:0]  r_bcid_err;
   logic [C_CNT_W-1:0]  r_trig_count;
   logic [C_CNT_W-1:0]  r_veto_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_valid <= 1'b0;
         r_trig_bcid  <= '0;
         r_trig_hits  <= '0;
      end else begin
         r_trig_valid <= w_issue;
         if (w_issue) begin
            r_trig_bcid <= r_s1_bcid;
            r_trig_hits <= w_coinc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_count <= '0;
      end else if (w_issue && (r_trig_count != '1)) begin
         r_trig_count <= r_trig_count + C_CNT_ONE;
      end
   end

   // A veto landing in the same cycle as err_clr is kept rather than lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_veto_count <= '0;
      end else if (err_clr) begin
         r_veto_count <= w_veto ? C_CNT_ONE : '0;
      end else if (w_veto && (r_veto_count != '1)) begin
         r_veto_count <= r_veto_count + C_CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcid_err <= '0;
      end else if (err_clr) begin
         r_bcid_err <= w_err_set;
      end else begin
         r_bcid_err <= r_bcid_err | w_err_set;
      end
   end

   assign trig_valid = r_trig_valid;
   assign trig_bcid  = r_trig_bcid;
   assign trig_hits  = r_trig_hits;
   assign bcid_err   = r_bcid_err;
   assign trig_count = r_trig_count;
   assign veto_count = r_veto_count;

endmodule

// File: tb/tb_pad_trigger_coincidence.sv
// Self-checking bench for pad_trigger_coincidence: directed scenarios plus a
// cycle-level behavioural model compared against the DUT on every falling edge.
module tb_pad_trigger_coincidence;

   localparam int DEAD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [115:0]  pad [4];
   logic          valid = 1'b0;
   logic [1:0]    ref_sel = 2'd0;
   logic [2:0]    threshold = 3'd0;
   logic          err_clr = 1'b0;

   logic          trig_valid;
   logic [11:0]   trig_bcid;
   logic [103:0]  trig_hits;
   logic [3:0]    bcid_err;
   logic [15:0]   trig_count;
   logic [15:0]   veto_count;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   pad_trigger_coincidence #(.DEADTIME(DEAD)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pad_data_0_aligned (pad[0]),
      .pad_data_1_aligned (pad[1]),
      .pad_data_2_aligned (pad[2]),
      .pad_data_3_aligned (pad[3]),
      .pad_data_valid_in  (valid),
      .ref_sel            (ref_sel),
      .threshold          (threshold),
      .err_clr            (err_clr),
      .trig_valid         (trig_valid),
      .trig_bcid          (trig_bcid),
      .trig_hits          (trig_hits),
      .bcid_err           (bcid_err),
      .trig_count         (trig_count),
      .veto_count         (veto_count)
   );

   // Behavioural model: what the outputs must be after each rising edge.
   logic          m_tv = 1'b0;
   logic [11:0]   m_bcid = '0;
   logic [103:0]  m_hits = '0;
   logic [3:0]    m_err = '0;
   logic [15:0]   m_tcnt = '0;
   logic [15:0]   m_vcnt = '0;
   logic          p_valid = 1'b0;
   logic [11:0]   p_bcid = '0;
   logic [3:0]    p_match = '0;
   logic [103:0]  p_hits [4];
   int            mcyc = 0;
   int            last_trig = 0;
   bit            have_last = 1'b0;
   logic [103:0]  mv_hits;
   logic [11:0]   mv_ref;
   logic [3:0]    mv_mis;
   int            mv_eff;
   int            mv_n;
   bit            mv_veto;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tv = 1'b0; m_bcid = '0; m_hits = '0; m_err = '0;
         m_tcnt = '0; m_vcnt = '0; p_valid = 1'b0; have_last = 1'b0;
      end else begin
         mcyc++;
         mv_eff = (threshold > 3'd4) ? 4 : int'(threshold);
         m_tv = 1'b0;
         mv_veto = 1'b0;
         if (p_valid) begin
            mv_hits = '0;
            for (int b = 0; b < 104; b++) begin
               mv_n = 0;
               for (int l = 0; l < 4; l++) if (p_match[l] && p_hits[l][b]) mv_n++;
               if (mv_eff != 0 && mv_n >= mv_eff) mv_hits[b] = 1'b1;
            end
            if (mv_hits != '0) begin
               if (!have_last || (mcyc - last_trig) > DEAD) begin
                  m_tv = 1'b1; m_bcid = p_bcid; m_hits = mv_hits;
                  if (m_tcnt != 16'hFFFF) m_tcnt++;
                  last_trig = mcyc; have_last = 1'b1;
               end else begin
                  mv_veto = 1'b1;
               end
            end
         end
         if (err_clr) m_vcnt = mv_veto ? 16'd1 : 16'd0;
         else if (mv_veto && m_vcnt != 16'hFFFF) m_vcnt++;
         mv_ref = pad[ref_sel][115:104];
         mv_mis = '0;
         for (int l = 0; l < 4; l++) if (valid && pad[l][115:104] != mv_ref) mv_mis[l] = 1'b1;
         m_err = err_clr ? mv_mis : (m_err | mv_mis);
         p_valid = valid;
         if (valid) begin
            p_bcid = mv_ref;
            p_match = ~mv_mis;
            for (int l = 0; l < 4; l++) p_hits[l] = pad[l][103:0];
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model trig_valid", 128'(trig_valid), 128'(m_tv));
         chk("model trig_bcid",  128'(trig_bcid),  128'(m_bcid));
         chk("model trig_hits",  128'(trig_hits),  128'(m_hits));
         chk("model bcid_err",   128'(bcid_err),   128'(m_err));
         chk("model trig_count", 128'(trig_count), 128'(m_tcnt));
         chk("model veto_count", 128'(veto_count), 128'(m_vcnt));
      end
   end

   task automatic set_pad(input int l, input logic [11:0] b, input logic [103:0] h);
      pad[l] = {b, h};
   endtask

   task automatic fire();
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " trig_valid"}, 128'(trig_valid), 128'(0));
      chk({tag, " trig_bcid"},  128'(trig_bcid),  128'(0));
      chk({tag, " trig_hits"},  128'(trig_hits),  128'(0));
      chk({tag, " bcid_err"},   128'(bcid_err),   128'(0));
      chk({tag, " trig_count"}, 128'(trig_count), 128'(0));
      chk({tag, " veto_count"}, 128'(veto_count), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   logic [103:0] h;

   initial begin
      for (int l = 0; l < 4; l++) pad[l] = '0;
      tick(3);
      chk_all_zero("reset");
      cmp_en = 1'b1;
      #2 rst_n = 1'b1;
      tick(2);

      // Three of four links agree on bit 7, threshold 3.
      $display("txn: bcid 0x123 bit7 on links 0-2, threshold 3");
      h = '0; h[7] = 1'b1;
      for (int l = 0; l < 3; l++) set_pad(l, 12'h123, h);
      set_pad(3, 12'h123, '0);
      threshold = 3'd3;
      fire();
      chk("lat1 trig_valid", 128'(trig_valid), 128'(0));
      @(negedge clk);
      chk("lat2 trig_valid", 128'(trig_valid), 128'(1));
      chk("t3 trig_bcid", 128'(trig_bcid), 128'(12'h123));
      chk("t3 trig_hits", 128'(trig_hits), 128'(h));
      chk("t3 trig_count", 128'(trig_count), 128'(1));
      tick(7);

      $display("txn: same stimulus, threshold 4");
      threshold = 3'd4;
      fire(); tick(1);
      chk("thr4 trig_valid", 128'(trig_valid), 128'(0));
      chk("thr4 bcid held", 128'(trig_bcid), 128'(12'h123));
      tick(2);

      $display("txn: same stimulus, threshold 0");
      for (int l = 0; l < 4; l++) set_pad(l, 12'h123, h);
      threshold = 3'd0;
      fire(); tick(1);
      chk("thr0 trig_valid", 128'(trig_valid), 128'(0));
      tick(2);

      $display("txn: link 2 bcid 0x124, bit5 all links, threshold 4");
      h = '0; h[5] = 1'b1;
      for (int l = 0; l < 4; l++) set_pad(l, (l == 2) ? 12'h124 : 12'h123, h);
      threshold = 3'd4;
      ref_sel = 2'd0;
      fire();
      chk("mis bcid_err", 128'(bcid_err), 128'(4'b0100));
      @(negedge clk);
      chk("mis trig_valid", 128'(trig_valid), 128'(0));
      err_clr = 1'b1; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("clr+repeat bcid_err", 128'(bcid_err), 128'(4'b0100));
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr bcid_err", 128'(bcid_err), 128'(0));
      tick(3);

      $display("txn: ref_sel 2, link 2 bcid 0x124, threshold 1");
      h = '0; h[9] = 1'b1;
      for (int l = 0; l < 4; l++) set_pad(l, 12'h123, h);
      h[11] = 1'b1;
      set_pad(2, 12'h124, h);
      threshold = 3'd1;
      ref_sel = 2'd2;
      fire();
      ref_sel = 2'd0;
      chk("ref2 bcid_err", 128'(bcid_err), 128'(4'b1011));
      @(negedge clk);
      chk("ref2 trig_valid", 128'(trig_valid), 128'(1));
      chk("ref2 trig_bcid", 128'(trig_bcid), 128'(12'h124));
      chk("ref2 trig_hits", 128'(trig_hits), 128'(h));
      tick(7);

      $display("txn: reset, then 6 back-to-back candidates");
      #2 rst_n = 1'b0;
      tick(2);
      #2 rst_n = 1'b1;
      tick(1);
      chk("rst2 trig_count", 128'(trig_count), 128'(0));
      h = '0; h[0] = 1'b1;
      for (int l = 0; l < 4; l++) set_pad(l, 12'h0A5, h);
      threshold = 3'd2;
      valid = 1'b1;
      tick(6);
      valid = 1'b0;
      tick(8);
      chk("b2b trig_count", 128'(trig_count), 128'(2));
      chk("b2b veto_count", 128'(veto_count), 128'(4));

      $display("txn: trig_count preloaded 0xFFFE, three triggers");
      #2;
      force dut.r_trig_count = 16'hFFFE;
      m_tcnt = 16'hFFFE;
      @(negedge clk);
      release dut.r_trig_count;
      for (int k = 0; k < 3; k++) begin
         fire(); tick(7);
      end
      chk("sat trig_count", 128'(trig_count), 128'(16'hFFFF));

      $display("txn: reset one cycle after candidate valid");
      fire();
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("postrst trig_valid", 128'(trig_valid), 128'(0));
      fire(); tick(1);
      chk("first trig_valid", 128'(trig_valid), 128'(1));
      chk("first trig_count", 128'(trig_count), 128'(1));
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
